br_ckpt_stack: RTL and testbench

Checkpoint storage driven by the branch mask controller. When a checkpointed branch dispatches, the block snapshots the rename map table, the free-list head and the ROB tail into the slot that matches the branch bit the controller allocates. On a mispredict it returns the snapshot for the resolved branch bit and invalidates all younger checkpoints. On a correct resolve it frees the slot. It sits between dispatch/rename and the ROB/free-list recovery paths.

---
 rtl/br_ckpt_stack_if.sv | 42 ++++
 rtl/br_ckpt_stack.sv | 97 +++++++++
 tb/tb_br_ckpt_stack.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/br_ckpt_stack_if.sv
// br_ckpt_stack_if: dispatch/resolve inputs and recovery outputs of the checkpoint stack.
`ifndef BR_MASK_W
`define BR_MASK_W 5
`endif
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
interface br_ckpt_stack_if #(
  parameter int BR_MASK_W = `BR_MASK_W,
  parameter int ARCH_REGS = 32,
  parameter int PRF_IDX_W = 6,
  parameter int FL_PTR_W  = 6,
  parameter int ROB_PTR_W = 5
);
  logic                           save_en_i;
  logic [BR_MASK_W-1:0]           br_mask_i;
  logic [ARCH_REGS*PRF_IDX_W-1:0] map_tbl_i;
  logic [FL_PTR_W-1:0]            fl_head_i;
  logic [ROB_PTR_W-1:0]           rob_tail_i;
  logic [`BR_STATE_W-1:0]         br_state_i;
  logic [BR_MASK_W-1:0]           br_bit_i;
  logic                           rc_valid_o;
  logic [ARCH_REGS*PRF_IDX_W-1:0] rc_map_tbl_o;
  logic [FL_PTR_W-1:0]            rc_fl_head_o;
  logic [ROB_PTR_W-1:0]           rc_rob_tail_o;
  logic [BR_MASK_W-1:0]           valid_o;
  logic                           full_o;
  modport master (
    output save_en_i, br_mask_i, map_tbl_i, fl_head_i, rob_tail_i, br_state_i, br_bit_i,
    input  rc_valid_o, rc_map_tbl_o, rc_fl_head_o, rc_rob_tail_o, valid_o, full_o
  );
  modport slave (
    input  save_en_i, br_mask_i, map_tbl_i, fl_head_i, rob_tail_i, br_state_i, br_bit_i,
    output rc_valid_o, rc_map_tbl_o, rc_fl_head_o, rc_rob_tail_o, valid_o, full_o
  );
endinterface

// File: rtl/br_ckpt_stack.sv
// br_ckpt_stack: per-branch rename/free-list/ROB checkpoints with mispredict recovery.
`ifndef BR_MASK_W
`define BR_MASK_W 5
`endif
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
module br_ckpt_stack #(
  parameter int BR_MASK_W = `BR_MASK_W,
  parameter int ARCH_REGS = 32,
  parameter int PRF_IDX_W = 6,
  parameter int FL_PTR_W  = 6,
  parameter int ROB_PTR_W = 5
) (
  input logic clk,
  input logic rst,
  br_ckpt_stack_if.slave bus
);
  localparam int MAP_W = ARCH_REGS*PRF_IDX_W;
  logic [BR_MASK_W-1:0] r_valid, w_valid_nx, w_avail, w_sel, w_save_dep, w_res_bit;
  logic [BR_MASK_W-1:0] r_dep [BR_MASK_W];
  logic [BR_MASK_W-1:0] w_dep_nx [BR_MASK_W];
  logic [MAP_W-1:0]     r_map [BR_MASK_W];
  logic [FL_PTR_W-1:0]  r_fl [BR_MASK_W];
  logic [ROB_PTR_W-1:0] r_rob [BR_MASK_W];
  logic [MAP_W-1:0]     r_rc_map, w_rc_map;
  logic [FL_PTR_W-1:0]  r_rc_fl, w_rc_fl;
  logic [ROB_PTR_W-1:0] r_rc_rob, w_rc_rob;
  logic                 w_wrong, w_correct, w_save, r_full, r_rc_valid;
  always_comb begin
    w_wrong    = bus.br_state_i == `BR_PR_WRONG;
    w_correct  = bus.br_state_i == `BR_PR_CORRECT;
    w_res_bit  = w_correct ? bus.br_bit_i : '0;
    w_save_dep = bus.br_mask_i & ~w_res_bit;
    w_avail    = ~w_save_dep;
    w_sel      = w_avail & (~w_avail + BR_MASK_W'(1));
    w_save     = bus.save_en_i & |w_avail & ~w_wrong;
    w_valid_nx = r_valid;
    w_rc_map   = '0;
    w_rc_fl    = '0;
    w_rc_rob   = '0;
    for (int i = 0; i < BR_MASK_W; i++) begin
      w_dep_nx[i] = r_dep[i] & ~w_res_bit;
      // a mispredict kills the branch itself and every checkpoint that depends on it
      if ((w_wrong && (bus.br_bit_i[i] || |(r_dep[i] & bus.br_bit_i))) || w_res_bit[i])
        w_valid_nx[i] = 1'b0;
      if (w_save && w_sel[i]) begin
        w_valid_nx[i] = 1'b1;
        w_dep_nx[i]   = w_save_dep;
      end
      w_rc_map = w_rc_map | (bus.br_bit_i[i] ? r_map[i] : '0);
      w_rc_fl  = w_rc_fl  | (bus.br_bit_i[i] ? r_fl[i]  : '0);
      w_rc_rob = w_rc_rob | (bus.br_bit_i[i] ? r_rob[i] : '0);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_full     <= 1'b0;
      r_rc_valid <= 1'b0;
      r_rc_map   <= '0;
      r_rc_fl    <= '0;
      r_rc_rob   <= '0;
      for (int i = 0; i < BR_MASK_W; i++) r_dep[i] <= '0;
    end else begin
      r_valid    <= w_valid_nx;
      r_full     <= &w_valid_nx;
      r_rc_valid <= w_wrong;
      for (int i = 0; i < BR_MASK_W; i++) r_dep[i] <= w_dep_nx[i];
      if (w_wrong) begin
        r_rc_map <= w_rc_map;
        r_rc_fl  <= w_rc_fl;
        r_rc_rob <= w_rc_rob;
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < BR_MASK_W; i++)
      if (w_save && w_sel[i]) begin
        r_map[i] <= bus.map_tbl_i;
        r_fl[i]  <= bus.fl_head_i;
        r_rob[i] <= bus.rob_tail_i;
      end
  end
  assign bus.valid_o       = r_valid;
  assign bus.full_o        = r_full;
  assign bus.rc_valid_o    = r_rc_valid;
  assign bus.rc_map_tbl_o  = r_rc_map;
  assign bus.rc_fl_head_o  = r_rc_fl;
  assign bus.rc_rob_tail_o = r_rc_rob;
endmodule

// File: tb/tb_br_ckpt_stack.sv
// tb_br_ckpt_stack: directed stimulus with queued expectations checked by a negedge monitor.
`ifndef BR_MASK_W
`define BR_MASK_W 5
`endif
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
module tb_br_ckpt_stack;
  localparam logic [1:0] W = `BR_PR_WRONG;
  localparam logic [1:0] C = `BR_PR_CORRECT;
  localparam logic [1:0] N = 2'b00;
  typedef struct {
    int         due;
    logic [4:0] v;
    logic       f;
    logic       rcv;
    logic       zero;
  } st_t;
  typedef struct {
    logic [191:0] map;
    logic [5:0]   fl;
    logic [4:0]   rob;
  } rc_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  st_t  sq[$];
  rc_t  rq[$];
  br_ckpt_stack_if dif();
  br_ckpt_stack dut (.clk(clk), .rst(rst), .bus(dif.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [191:0] mk_map(input logic [5:0] seed);
    logic [191:0] m;
    for (int r = 0; r < 32; r++) m[r*6 +: 6] = seed + 6'(r);
    return m;
  endfunction
  always @(posedge clk) begin
    if (!rst && dif.br_state_i != N)
      assert ($onehot(dif.br_bit_i)) else $error("resolve with non-one-hot br_bit_i %b", dif.br_bit_i);
    if (!rst && dif.br_state_i == W)
      assert (|(dif.valid_o & dif.br_bit_i)) else $error("wrong resolve on dead slot %b", dif.br_bit_i);
  end
  always @(negedge clk) begin
    st_t e;
    rc_t r;
    if (sq.size() != 0 && sq[0].due == cyc) begin
      e = sq.pop_front();
      checks++;
      if (dif.valid_o !== e.v || dif.full_o !== e.f || dif.rc_valid_o !== e.rcv) begin
        errors++;
        $display("FAIL state@%0d valid/full/rcv got %b/%b/%b exp %b/%b/%b", cyc,
                 dif.valid_o, dif.full_o, dif.rc_valid_o, e.v, e.f, e.rcv);
      end
      if (e.zero) begin
        checks++;
        if (dif.rc_map_tbl_o !== '0 || dif.rc_fl_head_o !== '0 || dif.rc_rob_tail_o !== '0) begin
          errors++;
          $display("FAIL rc_zero@%0d fl/rob got %0d/%0d exp 0/0 map %h", cyc,
                   dif.rc_fl_head_o, dif.rc_rob_tail_o, dif.rc_map_tbl_o);
        end
      end
    end
    if (dif.rc_valid_o === 1'b1) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rc_pulse@%0d got unexpected pulse exp none", cyc);
      end else begin
        r = rq.pop_front();
        if (dif.rc_map_tbl_o !== r.map || dif.rc_fl_head_o !== r.fl || dif.rc_rob_tail_o !== r.rob) begin
          errors++;
          $display("FAIL rc_data@%0d fl/rob got %0d/%0d exp %0d/%0d map_ok=%0b", cyc,
                   dif.rc_fl_head_o, dif.rc_rob_tail_o, r.fl, r.rob, dif.rc_map_tbl_o === r.map);
        end
      end
    end
  end
  task automatic exp_rc(input logic [5:0] fl, input logic [4:0] rob);
    rq.push_back('{mk_map(fl), fl, rob});
  endtask
  task automatic step(input logic r, input logic sv, input logic [4:0] mask, input logic [1:0] st,
                      input logic [4:0] bb, input logic [5:0] fl, input logic [4:0] rob,
                      input logic [4:0] ev, input logic ef, input logic erv, input logic ez);
    @(negedge clk);
    rst            = r;
    dif.save_en_i  = sv;
    dif.br_mask_i  = mask;
    dif.br_state_i = st;
    dif.br_bit_i   = bb;
    dif.fl_head_i  = fl;
    dif.rob_tail_i = rob;
    dif.map_tbl_i  = mk_map(fl);
    sq.push_back('{cyc + 1, ev, ef, erv, ez});
  endtask
  initial begin
    dif.save_en_i = 0; dif.br_mask_i = 0; dif.br_state_i = N; dif.br_bit_i = 0;
    dif.fl_head_i = 0; dif.rob_tail_i = 0; dif.map_tbl_i = '0;
    step(1, 1, 5'b00000, N, 5'b00000, 6'd9,  5'd9, 5'b00000, 0, 0, 1);
    step(1, 0, 5'b00000, N, 5'b00000, 6'd0,  5'd0, 5'b00000, 0, 0, 1);
    // save into empty stack, nested saves, mispredict on the middle branch
    step(0, 1, 5'b00000, N, 5'b00000, 6'd12, 5'd3, 5'b00001, 0, 0, 0);
    step(0, 1, 5'b00001, N, 5'b00000, 6'd20, 5'd5, 5'b00011, 0, 0, 0);
    step(0, 1, 5'b00011, N, 5'b00000, 6'd30, 5'd7, 5'b00111, 0, 0, 0);
    exp_rc(6'd20, 5'd5);
    step(0, 0, 5'b00111, W, 5'b00010, 6'd0,  5'd0, 5'b00001, 0, 1, 0);
    step(0, 0, 5'b00001, N, 5'b00000, 6'd0,  5'd0, 5'b00001, 0, 0, 0);
    exp_rc(6'd12, 5'd3);
    step(0, 0, 5'b00001, W, 5'b00001, 6'd0,  5'd0, 5'b00000, 0, 1, 0);
    // fill all five slots
    step(0, 1, 5'b00000, N, 5'b00000, 6'd1,  5'd1, 5'b00001, 0, 0, 0);
    step(0, 1, 5'b00001, N, 5'b00000, 6'd2,  5'd2, 5'b00011, 0, 0, 0);
    step(0, 1, 5'b00011, N, 5'b00000, 6'd3,  5'd3, 5'b00111, 0, 0, 0);
    step(0, 1, 5'b00111, N, 5'b00000, 6'd4,  5'd4, 5'b01111, 0, 0, 0);
    step(0, 1, 5'b01111, N, 5'b00000, 6'd5,  5'd5, 5'b11111, 1, 0, 0);
    step(0, 1, 5'b11111, N, 5'b00000, 6'd40, 5'd8, 5'b11111, 1, 0, 0);
    step(0, 1, 5'b11111, C, 5'b00100, 6'd50, 5'd9, 5'b11111, 1, 0, 0);
    // slot 2 now depends on slot 4, so killing 4 also kills 2; then back-to-back wrong on 3
    exp_rc(6'd5, 5'd5);
    step(0, 0, 5'b11111, W, 5'b10000, 6'd0,  5'd0, 5'b01011, 0, 1, 0);
    exp_rc(6'd4, 5'd4);
    step(0, 0, 5'b01011, W, 5'b01000, 6'd0,  5'd0, 5'b00011, 0, 1, 0);
    step(0, 0, 5'b00011, N, 5'b00000, 6'd0,  5'd0, 5'b00011, 0, 0, 0);
    exp_rc(6'd1, 5'd1);
    step(0, 1, 5'b00011, W, 5'b00001, 6'd60, 5'd6, 5'b00000, 0, 1, 0);
    step(0, 0, 5'b00000, N, 5'b00000, 6'd0,  5'd0, 5'b00000, 0, 0, 0);
    // correct resolve alone, then wrong, then reset during the recovery pulse
    step(0, 1, 5'b00000, N, 5'b00000, 6'd7,  5'd7, 5'b00001, 0, 0, 0);
    step(0, 1, 5'b00001, N, 5'b00000, 6'd8,  5'd8, 5'b00011, 0, 0, 0);
    step(0, 1, 5'b00011, N, 5'b00000, 6'd9,  5'd9, 5'b00111, 0, 0, 0);
    step(0, 0, 5'b00111, C, 5'b00001, 6'd0,  5'd0, 5'b00110, 0, 0, 0);
    exp_rc(6'd9, 5'd9);
    step(0, 0, 5'b00110, W, 5'b00100, 6'd0,  5'd0, 5'b00010, 0, 1, 0);
    step(1, 0, 5'b00010, N, 5'b00000, 6'd0,  5'd0, 5'b00000, 0, 0, 1);
    step(0, 0, 5'b00000, N, 5'b00000, 6'd0,  5'd0, 5'b00000, 0, 0, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (sq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d state/%0d rc pending exp 0/0", sq.size(), rq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
